// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous instruction
// memory addressed with next-PC, and hands instr/op/pc to decode with zero-bubble redirects.
module fetch_unit #(
  parameter int                 PC_W       = 10,
  parameter int                 INSTR_W    = 9,
  parameter int                 OFF_W      = 6,
  parameter int                 CNT_W      = 16,
  parameter logic [PC_W-1:0]    START_ADDR = {PC_W{1'b0}},
  parameter logic [INSTR_W-1:0] HALT_INSTR = 9'b110000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [OFF_W-1:0]   branch_offset,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         op,
  output logic [PC_W-1:0]    pc,
  output logic               instr_valid,
  output logic               done,
  output logic [CNT_W-1:0]   fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int              EXT_W   = (PC_W > OFF_W) ? PC_W : OFF_W;
  localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_r, state_s;
  logic [PC_W-1:0]    pc_r, pc_s, next_pc_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic               valid_r, done_r;
  logic               accept_s, halt_s;
  logic [EXT_W-1:0]   off_ext_s;

  // Offset is sign-extended to the wider of the two widths, then truncated so PC math wraps.
  assign off_ext_s = EXT_W'($signed(branch_offset));
  assign accept_s  = (state_r == S_RUN) & ~stall;
  assign halt_s    = accept_s & (imem_rdata == HALT_INSTR);

  // Next-state, next-PC and fetch counter.
  always_comb begin
    state_s   = state_r;
    next_pc_s = pc_r;
    pc_s      = pc_r;
    count_s   = count_r;
    case (state_r)
      S_IDLE: begin
        next_pc_s = START_ADDR;
        if (start) begin
          state_s = S_PRIME;
          pc_s    = START_ADDR;
          count_s = {CNT_W{1'b0}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_PRIME: begin
        next_pc_s = pc_r;
        state_s   = S_RUN;
      end
      S_RUN: begin
        // A halt parks the PC on itself so DONE holds the halt address.
        if (stall) begin
          next_pc_s = pc_r;
        end else if (halt_s) begin
          next_pc_s = pc_r;
          state_s   = S_DONE;
        end else if (jump) begin
          next_pc_s = jump_target;
        end else if (branch_taken) begin
          next_pc_s = pc_r + off_ext_s[PC_W-1:0];
        end else begin
          next_pc_s = pc_r + PC_ONE;
        end
        pc_s = next_pc_s;
        if (accept_s && (count_r != CNT_MAX)) begin
          count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          count_s = count_r;
        end
      end
      S_DONE: begin
        next_pc_s = pc_r;
        if (start) begin
          state_s = S_PRIME;
          pc_s    = START_ADDR;
          count_s = {CNT_W{1'b0}};
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s   = S_IDLE;
        next_pc_s = START_ADDR;
        pc_s      = START_ADDR;
        count_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, PC, counter and status flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      pc_r    <= START_ADDR;
      count_r <= {CNT_W{1'b0}};
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      count_r <= count_s;
      valid_r <= (state_s == S_RUN);
      done_r  <= (state_s == S_DONE);
    end
  end

  assign imem_addr   = next_pc_s;
  assign instr       = imem_rdata;
  assign op          = imem_rdata[INSTR_W-1 -: 6];
  assign pc          = pc_r;
  assign instr_valid = valid_r;
  assign done        = done_r;
  assign fetch_count = count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for redirect/stall/halt behaviour plus
// hand-written sequences for start-up, restart, PC wrap, counter saturation and reset.
module tb_fetch_unit;

  localparam logic [8:0] HALT = 9'b110000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // main instance (PC_W=10, CNT_W=16)
  logic       reset, start, stall, br, jmp;
  logic [5:0] off;
  logic [9:0] jt, imem_addr, pc;
  logic [8:0] rdata, instr;
  logic [5:0] op;
  logic       valid, done;
  logic [15:0] count;
  logic [8:0] mem [0:1023];

  // small instance (PC_W=4, CNT_W=3) for wrap and saturation
  logic       reset2, start2, stall2, br2, jmp2;
  logic [5:0] off2;
  logic [3:0] jt2, imem_addr2, pc2;
  logic [8:0] rdata2, instr2;
  logic [5:0] op2;
  logic       valid2, done2;
  logic [2:0] count2;
  logic [8:0] mem2 [0:15];

  fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(br), .branch_offset(off), .jump(jmp), .jump_target(jt),
    .imem_addr(imem_addr), .imem_rdata(rdata), .instr(instr), .op(op), .pc(pc),
    .instr_valid(valid), .done(done), .fetch_count(count)
  );

  fetch_unit #(.PC_W(4), .CNT_W(3), .START_ADDR(4'd0)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .stall(stall2),
    .branch_taken(br2), .branch_offset(off2), .jump(jmp2), .jump_target(jt2),
    .imem_addr(imem_addr2), .imem_rdata(rdata2), .instr(instr2), .op(op2), .pc(pc2),
    .instr_valid(valid2), .done(done2), .fetch_count(count2)
  );

  always_ff @(posedge clk) begin
    rdata  <= mem[imem_addr];
    rdata2 <= mem2[imem_addr2];
  end

  function automatic logic [8:0] f(input logic [9:0] a);
    f = {3'b001, a[5:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       stall, br;
    logic [5:0] off;
    logic       jmp;
    logic [9:0] jt;
    logic [9:0] epc;
    logic       ci;
    logic [8:0] einstr;
    logic       evalid, edone;
    logic [15:0] ecnt;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic b, input logic [5:0] o,
                              input logic j, input logic [9:0] t, input logic [9:0] p,
                              input logic ci, input logic [8:0] ei, input logic ev,
                              input logic ed, input logic [15:0] ec);
    mk.stall = s; mk.br = b; mk.off = o; mk.jmp = j; mk.jt = t;
    mk.epc = p; mk.ci = ci; mk.einstr = ei; mk.evalid = ev; mk.edone = ed; mk.ecnt = ec;
  endfunction

  vec_t vecs [20];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = f(10'(i));
    for (int i = 0; i < 16; i++) mem2[i] = f(10'(i));
    mem[4] = HALT;

    // outputs checked, then inputs driven for that same cycle
    vecs[0]  = mk(1'b0, 1'b0, 6'h00, 1'b0, 10'd0,   10'd0,  1'b1, f(10'd0),  1'b1, 1'b0, 16'd0);
    vecs[1]  = mk(1'b0, 1'b0, 6'h00, 1'b0, 10'd0,   10'd1,  1'b1, f(10'd1),  1'b1, 1'b0, 16'd1);
    vecs[2]  = mk(1'b0, 1'b0, 6'h00, 1'b0, 10'd0,   10'd2,  1'b1, f(10'd2),  1'b1, 1'b0, 16'd2);
    vecs[3]  = mk(1'b0, 1'b1, 6'h3E, 1'b0, 10'd0,   10'd3,  1'b1, f(10'd3),  1'b1, 1'b0, 16'd3);
    vecs[4]  = mk(1'b0, 1'b0, 6'h00, 1'b0, 10'd0,   10'd1,  1'b1, f(10'd1),  1'b1, 1'b0, 16'd4);
    vecs[5]  = mk(1'b0, 1'b0, 6'h00, 1'b0, 10'd0,   10'd2,  1'b1, f(10'd2),  1'b1, 1'b0, 16'd5);
    vecs[6]  = mk(1'b0, 1'b0, 6'h00, 1'b0, 10'd0,   10'd3,  1'b1, f(10'd3),  1'b1, 1'b0, 16'd6);
    vecs[7]  = mk(1'b0, 1'b0, 6'h00, 1'b0, 10'd0,   10'd4,  1'b1, f(10'd4),  1'b1, 1'b0, 16'd7);
    vecs[8]  = mk(1'b0, 1'b1, 6'h3E, 1'b1, 10'd40,  10'd5,  1'b1, f(10'd5),  1'b1, 1'b0, 16'd8);
    vecs[9]  = mk(1'b0, 1'b0, 6'h00, 1'b0, 10'd0,   10'd40, 1'b1, f(10'd40), 1'b1, 1'b0, 16'd9);
    vecs[10] = mk(1'b0, 1'b0, 6'h00, 1'b1, 10'd2,   10'd41, 1'b1, f(10'd41), 1'b1, 1'b0, 16'd10);
    vecs[11] = mk(1'b1, 1'b1, 6'h04, 1'b0, 10'd0,   10'd2,  1'b1, f(10'd2),  1'b1, 1'b0, 16'd11);
    vecs[12] = mk(1'b1, 1'b1, 6'h04, 1'b0, 10'd0,   10'd2,  1'b1, f(10'd2),  1'b1, 1'b0, 16'd11);
    vecs[13] = mk(1'b1, 1'b1, 6'h04, 1'b0, 10'd0,   10'd2,  1'b1, f(10'd2),  1'b1, 1'b0, 16'd11);
    vecs[14] = mk(1'b0, 1'b1, 6'h04, 1'b0, 10'd0,   10'd2,  1'b1, f(10'd2),  1'b1, 1'b0, 16'd11);
    vecs[15] = mk(1'b0, 1'b0, 6'h00, 1'b0, 10'd0,   10'd6,  1'b1, f(10'd6),  1'b1, 1'b0, 16'd12);
    vecs[16] = mk(1'b0, 1'b0, 6'h00, 1'b0, 10'd0,   10'd7,  1'b1, f(10'd7),  1'b1, 1'b0, 16'd13);
    vecs[17] = mk(1'b1, 1'b0, 6'h00, 1'b0, 10'd0,   10'd8,  1'b1, HALT,      1'b1, 1'b0, 16'd14);
    vecs[18] = mk(1'b0, 1'b1, 6'h3E, 1'b1, 10'd100, 10'd8,  1'b1, HALT,      1'b1, 1'b0, 16'd14);
    vecs[19] = mk(1'b0, 1'b0, 6'h00, 1'b0, 10'd0,   10'd8,  1'b0, 9'd0,      1'b0, 1'b1, 16'd15);

    reset = 1'b1; start = 1'b0; stall = 1'b0; br = 1'b0; off = 6'd0; jmp = 1'b0; jt = 10'd0;
    reset2 = 1'b1; start2 = 1'b0; stall2 = 1'b0; br2 = 1'b0; off2 = 6'd0; jmp2 = 1'b0; jt2 = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0; reset2 = 1'b0;

    // reset state
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pc",    32'(pc),    32'd0);
    chk("rst_iaddr", 32'(imem_addr), 32'd0);

    // straight-line run to a halt at 4
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("prime_valid", 32'(valid), 32'd0);
    chk("prime_iaddr", 32'(imem_addr), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("run1_valid", 32'(valid), 32'd1);
      chk("run1_pc",    32'(pc),    32'(i));
      chk("run1_instr", 32'(instr), (i < 4) ? 32'(f(10'(i))) : 32'(HALT));
      chk("run1_count", 32'(count), 32'(i));
    end
    @(negedge clk);
    chk("halt_done",  32'(done),  32'd1);
    chk("halt_valid", 32'(valid), 32'd0);
    chk("halt_count", 32'(count), 32'd5);
    chk("halt_pc",    32'(pc),    32'd4);

    // restart from DONE with new program contents
    mem[4] = f(10'd4);
    mem[8] = HALT;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_valid", 32'(valid), 32'd0);
    chk("restart_done",  32'(done),  32'd0);
    chk("restart_count", 32'(count), 32'd0);
    chk("restart_pc",    32'(pc),    32'd0);

    for (int v = 0; v < 20; v++) begin
      @(negedge clk);
      chk($sformatf("v%0d_pc", v),    32'(pc),    32'(vecs[v].epc));
      chk($sformatf("v%0d_valid", v), 32'(valid), 32'(vecs[v].evalid));
      chk($sformatf("v%0d_done", v),  32'(done),  32'(vecs[v].edone));
      chk($sformatf("v%0d_count", v), 32'(count), 32'(vecs[v].ecnt));
      if (vecs[v].ci) begin
        chk($sformatf("v%0d_instr", v), 32'(instr), 32'(vecs[v].einstr));
        chk($sformatf("v%0d_op", v),    32'(op),    32'(vecs[v].einstr[8:3]));
      end
      stall = vecs[v].stall; br = vecs[v].br; off = vecs[v].off;
      jmp = vecs[v].jmp; jt = vecs[v].jt;
    end
    stall = 1'b0; br = 1'b0; jmp = 1'b0;

    // narrow instance: PC wrap, count saturation, mid-run reset
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("w_prime_valid", 32'(valid2), 32'd0);
    @(negedge clk);
    chk("w_run_pc", 32'(pc2), 32'd0);
    jmp2 = 1'b1; jt2 = 4'd15;
    @(negedge clk);
    jmp2 = 1'b0;
    chk("w_pc15",    32'(pc2),    32'd15);
    chk("w_cnt15",   32'(count2), 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("w_pc",    32'(pc2),    32'(k));
      chk("w_instr", 32'(instr2), 32'(f(10'(k))));
      chk("w_count", 32'(count2), (k + 2 > 7) ? 32'd7 : 32'(k + 2));
    end
    reset2 = 1'b1;
    @(negedge clk);
    reset2 = 1'b0;
    chk("w_rst_valid", 32'(valid2), 32'd0);
    chk("w_rst_count", 32'(count2), 32'd0);
    chk("w_rst_done",  32'(done2),  32'd0);
    chk("w_rst_pc",    32'(pc2),    32'd0);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("w_prime2_valid", 32'(valid2), 32'd0);
    chk("w_prime2_pc",    32'(pc2),    32'd0);
    @(negedge clk);
    chk("w_run2_valid", 32'(valid2), 32'd1);
    chk("w_run2_instr", 32'(instr2), 32'(f(10'd0)));
    br2 = 1'b1; off2 = 6'h3E;
    @(negedge clk);
    br2 = 1'b0;
    chk("w_negwrap_pc",    32'(pc2),    32'd14);
    chk("w_negwrap_instr", 32'(instr2), 32'(f(10'd14)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
